// File: rtl/ahb_mtx_input_hold.sv
// Master-side input stage of the AHB bus matrix: forwards the address phase, holds it when
// the target output stage has not granted this port, and returns data-phase ready/response.
module ahb_mtx_input_hold (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  output logic        sel_dec,
  output logic [31:0] addr_dec,
  output logic [1:0]  trans_dec,
  output logic        write_dec,
  output logic [2:0]  size_dec,
  output logic [2:0]  burst_dec,
  output logic [3:0]  prot_dec,
  output logic        lock_dec,
  output logic        held_tran,
  input  logic        active_dec,
  input  logic        readyout_dec,
  input  logic        resp_dec
);

  logic        pend_q, pend_d;
  logic        data_phase_q, data_phase_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  trans_q, trans_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  burst_q, burst_d;
  logic [3:0]  prot_q, prot_d;
  logic        lock_q, lock_d;

  logic live_tran;
  logic capture;
  logic accept;

  always_comb begin
    live_tran = HSELS & HREADYS & HTRANSS[1];
    capture   = live_tran & ~active_dec & ~pend_q;
    accept    = (live_tran & active_dec & ~pend_q) | (pend_q & active_dec);

    pend_d  = pend_q;
    addr_d  = addr_q;
    trans_d = trans_q;
    write_d = write_q;
    size_d  = size_q;
    burst_d = burst_q;
    prot_d  = prot_q;
    lock_d  = lock_q;

    if (capture) begin
      pend_d  = 1'b1;
      addr_d  = HADDRS;
      trans_d = HTRANSS;
      write_d = HWRITES;
      size_d  = HSIZES;
      burst_d = HBURSTS;
      prot_d  = HPROTS;
      lock_d  = HMASTLOCKS;
    end else if (pend_q && active_dec) begin
      pend_d = 1'b0;
    end

    // Data phase opens on acceptance and closes when the target completes it.
    if (accept) begin
      data_phase_d = 1'b1;
    end else if (readyout_dec) begin
      data_phase_d = 1'b0;
    end else begin
      data_phase_d = data_phase_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q       <= 1'b0;
      data_phase_q <= 1'b0;
      addr_q       <= '0;
      trans_q      <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      burst_q      <= '0;
      prot_q       <= '0;
      lock_q       <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      data_phase_q <= data_phase_d;
      addr_q       <= addr_d;
      trans_q      <= trans_d;
      write_q      <= write_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      prot_q       <= prot_d;
      lock_q       <= lock_d;
    end
  end

  always_comb begin
    if (pend_q) begin
      sel_dec   = 1'b1;
      addr_dec  = addr_q;
      trans_dec = trans_q;
      write_dec = write_q;
      size_dec  = size_q;
      burst_dec = burst_q;
      prot_dec  = prot_q;
      lock_dec  = lock_q;
    end else begin
      sel_dec   = HSELS & HREADYS;
      addr_dec  = HADDRS;
      trans_dec = HTRANSS;
      write_dec = HWRITES;
      size_dec  = HSIZES;
      burst_dec = HBURSTS;
      prot_dec  = HPROTS;
      lock_dec  = HMASTLOCKS;
    end
  end

  assign held_tran  = pend_q;
  assign HREADYOUTS = data_phase_q ? readyout_dec : ~pend_q;
  assign HRESPS     = data_phase_q & resp_dec;

endmodule
